// File: rtl/doodle_event_ctrl.sv
// Doodle game event controller: turns per-frame collision events into the doodle's
// vertical step, monster-kill pulses, a saturating score and the game state.
module doodle_event_ctrl #(
  parameter logic [9:0]  JUMP_STEP    = 10'd9,
  parameter logic [9:0]  STOMP_STEP   = 10'd12,
  parameter logic [9:0]  MAX_FALL     = 10'd8,
  parameter int          GRAVITY_DIV  = 3,
  parameter int          DEATH_FRAMES = 60,
  parameter logic [15:0] STOMP_SCORE  = 16'd10,
  parameter logic [15:0] KILL_SCORE   = 16'd5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        start,
  input  logic        collision,
  input  logic        death,
  input  logic        beat_mons,
  input  logic        hit,
  output logic [9:0]  Ball_Y_Step,
  output logic        monster_kill,
  output logic [15:0] score,
  output logic        game_over,
  output logic        playing,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_DYING = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam int GW = (GRAVITY_DIV > 2) ? $clog2(GRAVITY_DIV) : 1;
  localparam int DW = (DEATH_FRAMES > 2) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [GW-1:0] GRAV_LAST  = GW'(GRAVITY_DIV - 1);
  localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_FRAMES - 1);
  localparam logic [9:0]    NEG_JUMP   = ~JUMP_STEP + 10'd1;
  localparam logic [9:0]    NEG_STOMP  = ~STOMP_STEP + 10'd1;

  logic          frame_dly_q;
  logic          fe_q;
  logic [1:0]    state_q, state_d;
  logic [9:0]    step_q, step_d;
  logic          kill_q, kill_d;
  logic [15:0]   score_q, score_d;
  logic          over_q, over_d;
  logic          play_q, play_d;
  logic [GW-1:0] grav_q, grav_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          descending;
  logic          at_max_fall;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // A bounce is only allowed while moving down; large positive values count as ascending.
  assign descending  = ~step_q[9] && (step_q < 10'd100);
  assign at_max_fall = $signed(step_q) >= $signed(MAX_FALL);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    kill_d  = 1'b0;
    score_d = score_q;
    grav_d  = grav_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        step_d = 10'd0;
        if (start) begin
          state_d = S_PLAY;
          step_d  = NEG_JUMP;
          score_d = 16'd0;
          grav_d  = '0;
        end
      end
      S_PLAY: begin
        if (fe_q) begin
          if (death && !beat_mons) begin
            state_d = S_DYING;
            step_d  = MAX_FALL;
            dcnt_d  = '0;
          end else if (beat_mons) begin
            step_d  = NEG_STOMP;
            kill_d  = 1'b1;
            score_d = sat_add(score_q, STOMP_SCORE);
            grav_d  = '0;
          end else begin
            if (collision && descending) begin
              step_d = NEG_JUMP;
              grav_d = '0;
            end else if (grav_q < GRAV_LAST) begin
              grav_d = grav_q + 1'b1;
            end else begin
              grav_d = '0;
              step_d = at_max_fall ? MAX_FALL : step_q + 10'd1;
            end
            // Bullet kills ride alongside motion when no stomp happened this frame.
            if (hit) begin
              kill_d  = 1'b1;
              score_d = sat_add(score_q, KILL_SCORE);
            end
          end
        end
      end
      S_DYING: begin
        if (fe_q) begin
          step_d = MAX_FALL;
          if (dcnt_q == DEATH_LAST) begin
            state_d = S_OVER;
            step_d  = 10'd0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    play_d = (state_d == S_PLAY);
    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_dly_q <= 1'b0;
      fe_q        <= 1'b0;
      state_q     <= S_IDLE;
      step_q      <= 10'd0;
      kill_q      <= 1'b0;
      score_q     <= 16'd0;
      over_q      <= 1'b0;
      play_q      <= 1'b0;
      grav_q      <= '0;
      dcnt_q      <= '0;
    end else begin
      frame_dly_q <= frame_clk;
      fe_q        <= frame_clk & ~frame_dly_q;
      state_q     <= state_d;
      step_q      <= step_d;
      kill_q      <= kill_d;
      score_q     <= score_d;
      over_q      <= over_d;
      play_q      <= play_d;
      grav_q      <= grav_d;
      dcnt_q      <= dcnt_d;
    end
  end

  assign Ball_Y_Step  = step_q;
  assign monster_kill = kill_q;
  assign score        = score_q;
  assign game_over    = over_q;
  assign playing      = play_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_doodle_event_ctrl.sv
// Bench for doodle_event_ctrl: frame-level reference model with integer arithmetic,
// directed scenario tasks plus a randomized event run.
module tb_doodle_event_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, start, collision, death, beat_mons, hit;
  logic [9:0]  Ball_Y_Step;
  logic        monster_kill;
  logic [15:0] score;
  logic        game_over, playing;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: 0 idle, 1 play, 2 dying, 3 over.
  int m_state, m_step, m_grav, m_dframes, m_score, m_kill;

  doodle_event_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
    .collision(collision), .death(death), .beat_mons(beat_mons), .hit(hit),
    .Ball_Y_Step(Ball_Y_Step), .monster_kill(monster_kill), .score(score),
    .game_over(game_over), .playing(playing), .dbg_state_o(dbg_state)
  );

  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_state = 0; m_step = 0; m_grav = 0; m_dframes = 0; m_score = 0; m_kill = 0;
  endtask

  task automatic model_start();
    if (m_state == 0 || m_state == 3) begin
      m_state = 1; m_step = -9; m_score = 0; m_grav = 0;
    end
  endtask

  task automatic model_frame(input bit c, input bit d, input bit b, input bit h);
    m_kill = 0;
    if (m_state == 1) begin
      if (d && !b) begin
        m_state = 2; m_step = 8; m_dframes = 0;
      end else if (b) begin
        m_step = -12; m_kill = 1; m_grav = 0;
        m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
      end else begin
        if (c && m_step >= 0 && m_step < 100) begin
          m_step = -9; m_grav = 0;
        end else begin
          m_grav = m_grav + 1;
          if (m_grav == 3) begin
            m_grav = 0;
            m_step = (m_step >= 8) ? 8 : m_step + 1;
          end
        end
        if (h) begin
          m_kill = 1;
          m_score = (m_score + 5 > 65535) ? 65535 : m_score + 5;
        end
      end
    end else if (m_state == 2) begin
      m_dframes = m_dframes + 1;
      if (m_dframes == 60) begin
        m_state = 3; m_step = 0;
      end
    end
  endtask

  // ---------------- drivers (all start and end at a negedge) ----------------
  task automatic do_reset();
    Reset = 1'b1; frame_clk = 1'b0; start = 1'b0;
    collision = 1'b0; death = 1'b0; beat_mons = 1'b0; hit = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    model_reset();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    model_start();
  endtask

  task automatic do_frame(input bit c, input bit d, input bit b, input bit h, output int kills);
    int low_len;
    low_len = $urandom_range(2, 4);
    collision = c; death = d; beat_mons = b; hit = h;
    frame_clk = 1'b1;
    kills = 0;
    repeat (2) begin
      @(negedge Clk);
      if (monster_kill) kills++;
    end
    frame_clk = 1'b0;
    collision = 1'b0; death = 1'b0; beat_mons = 1'b0; hit = 1'b0;
    repeat (low_len) begin
      @(negedge Clk);
      if (monster_kill) kills++;
    end
    model_frame(c, d, b, h);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b1; frame_clk = 1'b0; start = 1'b1;
    collision = 1'b1; death = 1'b1; beat_mons = 1'b1; hit = 1'b1;
    repeat (3) @(negedge Clk);
    n_checks++;
    if ({Ball_Y_Step, monster_kill, score, game_over, playing} !== 29'd0)
      $display("FAIL reset_outputs: got step=%h kill=%b score=%h over=%b play=%b, want all zero",
               Ball_Y_Step, monster_kill, score, game_over, playing);
    else n_pass++;
    do_reset();
    n_checks++;
    if (Ball_Y_Step !== 10'd0 || playing !== 1'b0)
      $display("FAIL idle_after_reset: got step=%h play=%b, want 000/0", Ball_Y_Step, playing);
    else n_pass++;
  endtask

  task automatic test_gravity();
    int k;
    do_reset();
    pulse_start();
    n_checks++;
    if (Ball_Y_Step !== 10'h3F7 || playing !== 1'b1)
      $display("FAIL start_step: got step=%h play=%b, want 3f7/1", Ball_Y_Step, playing);
    else n_pass++;
    for (int i = 1; i <= 56; i++) begin
      do_frame(0, 0, 0, 0, k);
      n_checks++;
      if (Ball_Y_Step !== 10'(m_step))
        $display("FAIL gravity_step f%0d: got %h want %h", i, Ball_Y_Step, 10'(m_step));
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (Ball_Y_Step !== 10'h3F8) $display("FAIL gravity_3frames: got %h want 3f8", Ball_Y_Step);
        else n_pass++;
      end
      if (i == 51 || i == 56) begin
        n_checks++;
        if (Ball_Y_Step !== 10'd8) $display("FAIL gravity_terminal f%0d: got %h want 008", i, Ball_Y_Step);
        else n_pass++;
      end
    end
    n_checks++;
    if (playing !== 1'b1 || game_over !== 1'b0)
      $display("FAIL gravity_state: got play=%b over=%b want 1/0", playing, game_over);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int k, guard;
    logic [15:0] sc;
    do_reset();
    pulse_start();
    guard = 0;
    while (m_step != 2 && guard < 100) begin
      do_frame(0, 0, 0, 0, k);
      guard++;
    end
    sc = score;
    do_frame(1, 0, 0, 0, k);
    n_checks++;
    if (Ball_Y_Step !== 10'h3F7 || score !== sc)
      $display("FAIL bounce_descending: got step=%h score=%h want 3f7/%h", Ball_Y_Step, score, sc);
    else n_pass++;
    guard = 0;
    while (m_step != -4 && guard < 100) begin
      do_frame(0, 0, 0, 0, k);
      guard++;
    end
    do_frame(1, 0, 0, 0, k);
    n_checks++;
    if (Ball_Y_Step !== 10'(m_step) || (Ball_Y_Step !== 10'h3FC && Ball_Y_Step !== 10'h3FD))
      $display("FAIL bounce_ascending_ignored: got %h want %h", Ball_Y_Step, 10'(m_step));
    else n_pass++;
  endtask

  task automatic test_stomp_and_hit();
    int k;
    do_reset();
    pulse_start();
    do_frame(0, 0, 1, 1, k);
    n_checks++;
    if (Ball_Y_Step !== 10'h3F4 || k !== 1 || score !== 16'd10)
      $display("FAIL stomp_hit: got step=%h kills=%0d score=%0d want 3f4/1/10", Ball_Y_Step, k, score);
    else n_pass++;
    do_frame(0, 1, 1, 0, k);
    n_checks++;
    if (playing !== 1'b1 || score !== 16'd20 || k !== 1)
      $display("FAIL stomp_beats_death: got play=%b score=%0d kills=%0d want 1/20/1", playing, score, k);
    else n_pass++;
    do_frame(0, 0, 0, 1, k);
    n_checks++;
    if (k !== 1 || score !== 16'd25)
      $display("FAIL hit_single: got kills=%0d score=%0d want 1/25", k, score);
    else n_pass++;
    begin
      int total;
      total = 0;
      for (int i = 0; i < 3; i++) begin
        do_frame(0, 0, 0, 1, k);
        total += k;
      end
      n_checks++;
      if (total !== 3 || score !== 16'd40)
        $display("FAIL hit_three_frames: got kills=%0d score=%0d want 3/40", total, score);
      else n_pass++;
    end
  endtask

  task automatic test_death();
    int k, bad;
    do_reset();
    pulse_start();
    do_frame(0, 0, 0, 1, k);
    do_frame(0, 1, 0, 1, k);
    n_checks++;
    if (Ball_Y_Step !== 10'd8 || playing !== 1'b0 || k !== 0 || score !== 16'd5)
      $display("FAIL death_enter: got step=%h play=%b kills=%0d score=%0d want 008/0/0/5",
               Ball_Y_Step, playing, k, score);
    else n_pass++;
    bad = 0;
    for (int i = 1; i < 60; i++) begin
      do_frame($urandom_range(0, 1), 0, $urandom_range(0, 1), $urandom_range(0, 1), k);
      if (Ball_Y_Step !== 10'd8 || game_over !== 1'b0 || playing !== 1'b0 || k !== 0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL dying_hold: got %0d bad frames want 0", bad);
    else n_pass++;
    do_frame(0, 0, 0, 0, k);
    n_checks++;
    if (game_over !== 1'b1 || Ball_Y_Step !== 10'd0 || score !== 16'd5)
      $display("FAIL game_over: got over=%b step=%h score=%0d want 1/000/5", game_over, Ball_Y_Step, score);
    else n_pass++;
    pulse_start();
    n_checks++;
    if (playing !== 1'b1 || game_over !== 1'b0 || score !== 16'd0 || Ball_Y_Step !== 10'h3F7)
      $display("FAIL restart: got play=%b over=%b score=%0d step=%h want 1/0/0/3f7",
               playing, game_over, score, Ball_Y_Step);
    else n_pass++;
  endtask

  task automatic test_reset_mid_dying();
    int k;
    do_reset();
    pulse_start();
    do_frame(0, 1, 0, 0, k);
    repeat (10) do_frame(0, 0, 0, 0, k);
    Reset = 1'b1;
    @(negedge Clk);
    n_checks++;
    if ({Ball_Y_Step, monster_kill, score, game_over, playing} !== 29'd0)
      $display("FAIL reset_mid_dying: got step=%h kill=%b score=%h over=%b play=%b want zeros",
               Ball_Y_Step, monster_kill, score, game_over, playing);
    else n_pass++;
    Reset = 1'b0;
    @(negedge Clk);
    model_reset();
  endtask

  task automatic test_saturation();
    int k;
    do_reset();
    pulse_start();
    for (int i = 0; i < 6553; i++) do_frame(0, 0, 1, 0, k);
    n_checks++;
    if (score !== 16'hFFFA) $display("FAIL score_preset: got %h want fffa", score);
    else n_pass++;
    do_frame(0, 0, 1, 0, k);
    n_checks++;
    if (score !== 16'hFFFF) $display("FAIL score_saturate: got %h want ffff", score);
    else n_pass++;
    do_frame(0, 0, 0, 1, k);
    n_checks++;
    if (score !== 16'hFFFF || k !== 1) $display("FAIL score_hold: got %h kills=%0d want ffff/1", score, k);
    else n_pass++;
  endtask

  task automatic test_random();
    int k;
    bit c, d, b, h;
    do_reset();
    pulse_start();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) pulse_start();
      c = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 24) == 0);
      b = ($urandom_range(0, 7) == 0);
      h = ($urandom_range(0, 4) == 0);
      do_frame(c, d, b, h, k);
      n_checks++;
      if (Ball_Y_Step !== 10'(m_step) || score !== 16'(m_score))
        $display("FAIL rand_motion f%0d: got step=%h score=%0d want %h/%0d",
                 i, Ball_Y_Step, score, 10'(m_step), m_score);
      else n_pass++;
      n_checks++;
      if (playing !== (m_state == 1) || game_over !== (m_state == 3) || k !== m_kill)
        $display("FAIL rand_status f%0d: got play=%b over=%b kills=%0d want %0d/%0d/%0d",
                 i, playing, game_over, k, m_state == 1, m_state == 3, m_kill);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_gravity();
    test_bounce();
    test_stomp_and_hit();
    test_death();
    test_reset_mid_dying();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
